// File: rtl/branch_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
package branch_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;
  localparam int   PC_STEP   = 4;

  // Two-bit saturating step toward the resolved outcome.
  function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
    ctr_t nxt;
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = ctr_t'(cur + 2'd1);
    end else begin
      if (cur != SNT) nxt = ctr_t'(cur - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// Table of 2-bit saturating counters: one combinational read port and
// one synchronous update port.
module branch_history_table
  import branch_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr_t             rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  ctr_t table_q [ENTRIES];

  // A read that collides with an update sees the old value; the write lands at the edge.
  assign rd_ctr = table_q[rd_idx];

  // NOTE: the counter array is reset explicitly (it is flops, not a RAM macro) so that
  // predictions are deterministic from the first fetch after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_RESET;
    end else if (wr_en) begin
      table_q[wr_idx] <= ctr_next(table_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_predict_fetch.sv
// Fetch PC owner: predicts conditional branches, redirects on execute-stage
// mispredicts, trains the counter table and counts mispredicts.
module branch_predict_fetch
  import branch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ENTRIES  = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  output logic [XLEN-1:0] fetch_pc,
  input  logic            if_is_branch,
  input  logic [XLEN-1:0] if_target,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            flush,
  output logic [31:0]     mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [31:0]     cnt_q;
  logic            mispredict;
  ctr_t            rd_ctr;

  branch_history_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_idx   (pc_q[IDX_W+1:2]),
    .rd_ctr   (rd_ctr),
    .wr_en    (ex_valid),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_taken (ex_taken)
  );

  assign pred_taken = if_is_branch & rd_ctr[1];

  // Straight from the execute inputs: no register between ex_* and flush.
  assign mispredict = ex_valid & (ex_taken != ex_pred_taken);
  assign flush      = mispredict;

  // NOTE: combinational blocks assign a default first so no path leaves pc_d
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_d = pc_q + STEP;
    if (mispredict)      pc_d = ex_taken ? ex_target : ex_pc + STEP;
    else if (stall)      pc_d = pc_q;
    else if (pred_taken) pc_d = if_target;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (mispredict && (cnt_q != 32'hFFFF_FFFF)) cnt_q <= cnt_q + 32'd1;
    end
  end

  assign fetch_pc       = pc_q;
  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_predict_fetch.sv
// Directed plus randomized bench for branch_predict_fetch, checked against
// a behavioural model of PC sequencing, counter training and mispredict count.
module tb_branch_predict_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic [63:0] fetch_pc;
  logic        if_is_branch;
  logic [63:0] if_target;
  logic        pred_taken;
  logic        ex_valid;
  logic [63:0] ex_pc;
  logic        ex_taken;
  logic [63:0] ex_target;
  logic        ex_pred_taken;
  logic        flush;
  logic [31:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [63:0] m_pc;
  int          m_ctr [16];
  logic [31:0] m_cnt;
  bit          m_known = 1'b0;

  branch_predict_fetch #(
    .XLEN     (64),
    .ENTRIES  (16),
    .RESET_PC (64'h0)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .fetch_pc       (fetch_pc),
    .if_is_branch   (if_is_branch),
    .if_target      (if_target),
    .pred_taken     (pred_taken),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .flush          (flush),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int slot(input logic [63:0] pc);
    return int'((pc / 64'd4) % 64'd16);
  endfunction

  // One clock: inputs already driven; checks combinational outputs, then
  // registered outputs after the edge. Returns at the following negedge.
  task automatic cycle();
    logic        exp_pred;
    logic        exp_mis;
    logic [63:0] nxt_pc;
    int          s;
    #1;
    exp_mis = ex_valid && (ex_taken != ex_pred_taken);
    check("flush", 64'(flush), 64'(exp_mis));
    exp_pred = 1'b0;
    if (m_known) begin
      exp_pred = if_is_branch && (m_ctr[slot(m_pc)] >= 2);
      check("pred_taken", 64'(pred_taken), 64'(exp_pred));
    end
    if (exp_mis)         nxt_pc = ex_taken ? ex_target : ex_pc + 64'd4;
    else if (stall)      nxt_pc = m_pc;
    else if (exp_pred)   nxt_pc = if_target;
    else                 nxt_pc = m_pc + 64'd4;
    @(posedge clk);
    if (!reset_n) begin
      m_pc  = 64'h0;
      m_cnt = 32'h0;
      for (int i = 0; i < 16; i++) m_ctr[i] = 1;
      m_known = 1'b1;
    end else if (m_known) begin
      m_pc = nxt_pc;
      if (ex_valid) begin
        s = slot(ex_pc);
        if (ex_taken) m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
        else          m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
      end
      if (exp_mis && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    #1;
    if (m_known) begin
      check("fetch_pc", fetch_pc, m_pc);
      check("mispredict_cnt", 64'(mispredict_cnt), 64'(m_cnt));
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 1'b0; if_is_branch = 1'b0; if_target = 64'h0;
    ex_valid = 1'b0; ex_pc = 64'h0; ex_taken = 1'b0;
    ex_target = 64'h0; ex_pred_taken = 1'b0;
  endtask

  task automatic random_inputs();
    stall         = ($urandom_range(0, 3) == 0);
    if_is_branch  = $urandom_range(0, 1) == 1;
    case ($urandom_range(0, 3))
      0:       if_target = 64'hFFFF_FFFF_FFFF_FFFC;
      1:       if_target = {$urandom(), $urandom()};
      default: if_target = 64'($urandom_range(0, 255)) * 64'd4;
    endcase
    ex_valid      = $urandom_range(0, 1) == 1;
    ex_pc         = ($urandom_range(0, 1) == 1) ? {$urandom(), $urandom()}
                                                : 64'($urandom_range(0, 255)) * 64'd4;
    ex_taken      = $urandom_range(0, 1) == 1;
    ex_pred_taken = $urandom_range(0, 1) == 1;
    ex_target     = 64'($urandom_range(0, 1023)) * 64'd4;
  endtask

  initial begin
    // Reset with random inputs for two edges
    reset_n = 1'b0;
    random_inputs();
    cycle();
    random_inputs();
    cycle();
    check("reset_pc", fetch_pc, 64'h0);
    check("reset_cnt", 64'(mispredict_cnt), 64'h0);

    // Sequential fetch; branch at reset PC predicts not-taken
    reset_n = 1'b1;
    idle_inputs();
    if_is_branch = 1'b1;
    if_target    = 64'h900;
    #1;
    check("reset_pred", 64'(pred_taken), 64'h0);
    cycle();
    if_is_branch = 1'b0;
    cycle();
    cycle();
    check("seq_0xc", fetch_pc, 64'hC);
    stall = 1'b1;
    cycle();
    cycle();
    check("stall_hold", fetch_pc, 64'hC);

    // Training: correct taken still trains, then taken mispredict to 0x40
    stall = 1'b0; ex_valid = 1'b1; ex_pc = 64'h40; ex_taken = 1'b1; ex_pred_taken = 1'b1;
    cycle();
    ex_pred_taken = 1'b0; ex_target = 64'h40;
    cycle();
    check("redirect_0x40", fetch_pc, 64'h40);
    idle_inputs();
    if_is_branch = 1'b1; if_target = 64'h80;
    #1;
    check("pred_0x40", 64'(pred_taken), 64'h1);
    cycle();
    check("follow_0x80", fetch_pc, 64'h80);

    // Not-taken mispredict under stall
    idle_inputs();
    stall = 1'b1; ex_valid = 1'b1; ex_pc = 64'h100; ex_taken = 1'b0; ex_pred_taken = 1'b1;
    #1;
    check("flush_same_cycle", 64'(flush), 64'h1);
    cycle();
    check("redirect_0x104", fetch_pc, 64'h104);

    // Taken mispredict, then saturation of the mispredict counter
    stall = 1'b0; ex_pc = 64'h1F8; ex_taken = 1'b1; ex_pred_taken = 1'b0; ex_target = 64'h200;
    cycle();
    check("redirect_0x200", fetch_pc, 64'h200);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    ex_target = 64'h208;
    cycle();
    check("cnt_saturate", 64'(mispredict_cnt), 64'hFFFF_FFFF);

    // Same-index collision: stalled fetch sees old value, then trained value
    idle_inputs();
    stall = 1'b1; if_is_branch = 1'b1; if_target = 64'h400;
    ex_valid = 1'b1; ex_pc = 64'h208; ex_taken = 1'b1; ex_pred_taken = 1'b1;
    #1;
    check("collide_old", 64'(pred_taken), 64'h0);
    cycle();
    stall = 1'b0; ex_valid = 1'b0;
    #1;
    check("collide_new", 64'(pred_taken), 64'h1);
    cycle();
    check("collide_follow", fetch_pc, 64'h400);

    // Reset during a mispredict discards it
    idle_inputs();
    reset_n = 1'b0; ex_valid = 1'b1; ex_pc = 64'h500; ex_taken = 1'b1;
    ex_pred_taken = 1'b0; ex_target = 64'h600;
    cycle();
    check("midreset_pc", fetch_pc, 64'h0);
    check("midreset_cnt", 64'(mispredict_cnt), 64'h0);
    reset_n = 1'b1;
    idle_inputs();
    cycle();
    check("after_reset_pc", fetch_pc, 64'h4);

    // PC wrap at the top of the address space
    ex_valid = 1'b1; ex_pc = 64'h20; ex_taken = 1'b1; ex_pred_taken = 1'b0;
    ex_target = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    idle_inputs();
    cycle();
    check("pc_wrap", fetch_pc, 64'h0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      random_inputs();
      reset_n = ($urandom_range(0, 59) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_fetch.md
# branch_predict_fetch

Fetch-side counterpart to the execute-stage branch comparator in the 2.5-stage pipeline. Owns the program counter, predicts conditional branches at fetch with a table of 2-bit saturating counters, consumes the resolved outcome from execute, and on a mispredict raises a flush and redirects the PC. It also trains the table and counts mispredicts for performance reporting.

## Interface
- `XLEN`, 64: address width.
- `ENTRIES`, 16: number of prediction counters; power of two, ≥2; `IDX_W = log2(ENTRIES)`.
- `RESET_PC`, 64'h0: PC value after reset.

Ports:
- `clk`  in  1  — single clock, all state on rising edge.
- `reset_n`  in  1  — synchronous, active-low reset.
- `stall`  in  1  — hold `fetch_pc`. Ignored while a mispredict is being redirected.
- `fetch_pc`  out  XLEN  — address of the instruction being fetched.
- `if_is_branch`  in  1  — predecode: the instruction at `fetch_pc` is a conditional branch.
- `if_target`  in  XLEN  — branch target computed at fetch.
- `pred_taken`  out  1  — prediction for `fetch_pc`. The pipeline carries it to execute.
- `ex_valid`  in  1  — a conditional branch resolves in execute this cycle.
- `ex_pc`  in  XLEN  — PC of the resolving branch.
- `ex_taken`  in  1  — actual outcome from the branch comparator.
- `ex_target`  in  XLEN  — actual taken target.
- `ex_pred_taken`  in  1  — prediction that travelled with the branch.
- `flush`  out  1  — kill younger instructions in IF/ID.
- `mispredict_cnt`  out  32  — saturating count of mispredicts.

## Operation
**Index**
- `idx(pc) = pc[IDX_W+1:2]`.

**Prediction**
- `pred_taken = if_is_branch & ctr[idx(fetch_pc)][1]`.

**Mispredict**
- `mispredict = ex_valid & (ex_taken != ex_pred_taken)`.
- `flush = mispredict`.

**Next-PC priority (highest first)**
- `mispredict`: next PC is `ex_taken ? ex_target : ex_pc + 4`.
- `stall`: hold.
- `pred_taken`: next PC is `if_target`.
- Otherwise: `fetch_pc + 4`.
- All adds are modulo 2^XLEN and wrap silently.

**Training (every cycle with `ex_valid`, correct or not)**
- `ctr[idx(ex_pc)]` increments if `ex_taken`, else decrements.
- Counters saturate at 2'b11 and 2'b00.
- A branch correctly predicted taken still trains.

**Mispredict counter**
- `mispredict_cnt` increments on `mispredict` and holds at 32'hFFFF_FFFF.

**Collisions and simultaneous events**
- Same-cycle read and write to one index: the prediction uses the pre-update value, and the write lands at the edge.
- Aliasing between PCs sharing an index is permitted and not detected.
- `stall` together with `mispredict`: the redirect wins and `stall` is ignored that cycle.
- `stall` does not block training.

**Reset values (on any edge with `reset_n` = 0, including mid-operation)**
- `fetch_pc = RESET_PC`.
- All counters = 2'b01 (weakly not-taken).
- `mispredict_cnt = 0`.
- In-flight resolution inputs that cycle are discarded; no training occurs.

## Timing
- `fetch_pc`, counters and `mispredict_cnt` are registered.
- `pred_taken` and `flush` are combinational. There is no register between `ex_*` and `flush`.
- Redirect latency is 1 cycle: mispredict sampled at edge N, so `fetch_pc` holds the corrected address after edge N.
- Training is visible to a prediction from the cycle after the update edge.
- Reset is synchronous: outputs reach reset values at the first edge with `reset_n` low. The first fetch of `RESET_PC` starts in the cycle after `reset_n` rises.
- Combinational path of concern: `ex_*` → compare → next-PC mux. It must close within one cycle at the pipeline's target frequency.

## Structure
**Shared package `branch_pkg`**
- Counter encodings: `SNT = 2'b00`, `WNT = 2'b01`, `WT = 2'b10`, `ST = 2'b11`.
- `CTR_RESET = WNT`.
- Instruction step `PC_STEP = 4`.

**Sub-module `branch_history_table`**
- Holds the ENTRIES×2 counter array.
- One combinational read port and one synchronous saturating update port.
- Synchronous active-low reset to `CTR_RESET`.

**Top level**
- Holds the PC register, next-PC mux, mispredict compare and perf counter.

## Test plan
1. **Reset:** hold `reset_n` = 0 for 2 edges with random inputs → `fetch_pc` = 0, `mispredict_cnt` = 0, `pred_taken` = 0 for any `fetch_pc` with `if_is_branch` = 1.
2. **Sequential fetch:** no branches for 4 cycles from reset → `fetch_pc` = 0x0, 0x4, 0x8, 0xC. Assert `stall` for 2 cycles → `fetch_pc` holds 0xC.
3. **Training:** `ex_valid` with `ex_pc` = 0x40, `ex_taken` = 1, twice → `ctr[0]` goes 01 → 10 → 11. Then with `fetch_pc` = 0x40, `if_is_branch` = 1, `if_target` = 0x80 → `pred_taken` = 1 and the next `fetch_pc` is 0x80.
4. **Mispredict redirect:** `ex_valid`, `ex_pc` = 0x100, `ex_taken` = 0, `ex_pred_taken` = 1, with `stall` = 1 → `flush` = 1 the same cycle, `fetch_pc` = 0x104 next cycle, `mispredict_cnt` +1, and the counter decrements.
5. **Taken mispredict:** `ex_taken` = 1, `ex_pred_taken` = 0, `ex_target` = 0x200 → `fetch_pc` = 0x200. Force `mispredict_cnt` to 0xFFFF_FFFF then mispredict again → it holds 0xFFFF_FFFF.
6. **Same-index collision and mid-operation reset:** fetch and resolve to the same index (`ctr` = 01, resolve taken) → prediction 0 that cycle and 1 the next cycle. Pulse `reset_n` = 0 during a mispredict → no flush effect after reset, and `fetch_pc` = 0.
